// File: rtl/ysyx_22050133_pkg.sv
// ysyx_22050133_pkg: shared widths and the fetch-queue entry type
package ysyx_22050133_pkg;
  localparam int PC_W = 64;
  localparam int INST_W = 32;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ifq_entry_t;
endpackage

// File: rtl/ysyx_22050133_ifq_mem.sv
// ysyx_22050133_ifq_mem: DEPTH x entry register array, sync write, async read, no reset
// ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port
module ysyx_22050133_ifq_mem
  import ysyx_22050133_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  ifq_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output ifq_entry_t    rdata
);
  ifq_entry_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ysyx_22050133_ifq.sv
// ysyx_22050133_ifq: in-order fetch-to-decode instruction queue with redirect flush
// ports: clk; rst (async, active-low); flush drops contents and the offered beat;
//   in_valid/in_ready/in_pc/in_inst from fetch; out_valid/out_ready/out_pc/out_inst to decode;
//   count = occupancy
// YSYX_22050133_IFQ_BYPASS_EN: when empty, in_* passes straight to out_* in the same cycle
module ysyx_22050133_ifq
  import ysyx_22050133_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CW-1:0]     count
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  ifq_entry_t head, wdata;
  assign wdata = '{pc: in_pc, inst: in_inst};
  assign in_ready = count != CW'(DEPTH);
`ifdef YSYX_22050133_IFQ_BYPASS_EN
  logic byp;
  assign byp = count == '0 && in_valid && !flush;
  assign out_valid = (count != '0 || in_valid) && !flush;
  assign {out_pc, out_inst} = !out_valid ? '0 : byp ? {in_pc, in_inst} : head;
  // a bypassed beat taken by decode this cycle never enters storage
  assign push = in_valid && in_ready && !flush && !(byp && out_ready);
`else
  assign out_valid = count != '0 && !flush;
  assign {out_pc, out_inst} = out_valid ? head : '0;
  assign push = in_valid && in_ready && !flush;
`endif
  assign pop = out_valid && out_ready && count != '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  ysyx_22050133_ifq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(wdata),
    .raddr(rd_ptr),
    .rdata(head)
  );
endmodule

// File: tb/tb_ysyx_22050133_ifq.sv
// tb_ysyx_22050133_ifq: directed table plus queue-scoreboard checks of the fetch queue
module tb_ysyx_22050133_ifq;
  import ysyx_22050133_pkg::*;
  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_pc, out_pc;
  logic [31:0] in_inst, out_inst;
  logic [CW-1:0] count;
  int tests = 0, fails = 0;
  ifq_entry_t q[$];
  ysyx_22050133_ifq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .count(count)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [63:0] pc, input logic [31:0] inst);
    in_valid = iv;
    out_ready = ordy;
    flush = fl;
    in_pc = pc;
    in_inst = inst;
  endtask
  // one cycle against the reference queue: check outputs before the edge, update model after it
  task automatic step(input string name);
    logic ev, acc, pop, byp;
    logic [63:0] epc;
    logic [31:0] einst;
    #1;
    byp = 0;
`ifdef YSYX_22050133_IFQ_BYPASS_EN
    byp = q.size() == 0 && in_valid && !flush;
`endif
    ev = (q.size() != 0 || byp) && !flush;
    epc = !ev ? 64'h0 : byp ? in_pc : q[0].pc;
    einst = !ev ? 32'h0 : byp ? in_inst : q[0].inst;
    chk({name, "_valid"}, out_valid, ev);
    chk({name, "_ready"}, in_ready, q.size() < DEPTH);
    chk({name, "_pc"}, out_pc, epc);
    chk({name, "_inst"}, out_inst, einst);
    pop = ev && out_ready && q.size() != 0;
    acc = in_valid && q.size() < DEPTH && !flush && !(byp && out_ready);
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{pc: in_pc, inst: in_inst});
    end
    chk({name, "_count"}, 64'(count), 64'(q.size()));
  endtask
  typedef struct {
    logic iv, ordy, fl;
    logic [63:0] pc;
    logic [31:0] inst;
    logic ev, er;
    logic [63:0] epc;
    logic [31:0] einst;
    int ecnt;
  } vec_t;
  vec_t tv[16];
  initial begin
    tv[0]  = '{1, 0, 0, 64'h8000_0000, 32'h0413, 0, 1, 64'h0, 32'h0, 1};
    tv[1]  = '{1, 0, 0, 64'h8000_0004, 32'h0513, 1, 1, 64'h8000_0000, 32'h0413, 2};
    tv[2]  = '{1, 0, 0, 64'h8000_0008, 32'h0613, 1, 0, 64'h8000_0000, 32'h0413, 2};
    tv[3]  = '{0, 1, 0, 64'h0, 32'h0, 1, 0, 64'h8000_0000, 32'h0413, 1};
    tv[4]  = '{0, 1, 0, 64'h0, 32'h0, 1, 1, 64'h8000_0004, 32'h0513, 0};
    tv[5]  = '{0, 1, 0, 64'h0, 32'h0, 0, 1, 64'h0, 32'h0, 0};
    tv[6]  = '{1, 0, 0, 64'h8000_0008, 32'h0713, 0, 1, 64'h0, 32'h0, 1};
    tv[7]  = '{1, 0, 0, 64'h8000_000C, 32'h0813, 1, 1, 64'h8000_0008, 32'h0713, 2};
    tv[8]  = '{1, 1, 0, 64'h8000_0010, 32'h0913, 1, 0, 64'h8000_0008, 32'h0713, 1};
    tv[9]  = '{1, 0, 0, 64'h8000_0014, 32'h0A13, 1, 1, 64'h8000_000C, 32'h0813, 2};
    tv[10] = '{1, 1, 1, 64'h8000_0010, 32'h0B13, 0, 0, 64'h0, 32'h0, 0};
    tv[11] = '{0, 1, 0, 64'h0, 32'h0, 0, 1, 64'h0, 32'h0, 0};
    tv[12] = '{1, 0, 0, 64'h8000_0018, 32'h0C13, 0, 1, 64'h0, 32'h0, 1};
    tv[13] = '{0, 1, 0, 64'h0, 32'h0, 1, 1, 64'h8000_0018, 32'h0C13, 0};
    tv[14] = '{1, 0, 1, 64'h8000_001C, 32'h0D13, 0, 1, 64'h0, 32'h0, 0};
    tv[15] = '{0, 0, 0, 64'h0, 32'h0, 0, 1, 64'h0, 32'h0, 0};
    rst = 0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_pc", out_pc, 0);
    chk("rst_inst", out_inst, 0);
    rst = 1;
`ifndef YSYX_22050133_IFQ_BYPASS_EN
    for (int i = 0; i < 16; i++) begin
      drive(tv[i].iv, tv[i].ordy, tv[i].fl, tv[i].pc, tv[i].inst);
      #1;
      chk($sformatf("v%0d_valid", i), out_valid, tv[i].ev);
      chk($sformatf("v%0d_ready", i), in_ready, tv[i].er);
      chk($sformatf("v%0d_pc", i), out_pc, tv[i].epc);
      chk($sformatf("v%0d_inst", i), out_inst, tv[i].einst);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), 64'(count), 64'(tv[i].ecnt));
    end
`else
    drive(1, 1, 0, 64'h8000_0020, 32'h0E13);
    #1;
    chk("byp_valid", out_valid, 1);
    chk("byp_pc", out_pc, 64'h8000_0020);
    chk("byp_inst", out_inst, 32'h0E13);
    @(posedge clk);
    #1;
    chk("byp_count", 64'(count), 0);
`endif
    drive(0, 0, 0, 0, 0);
    q.delete();
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 64'h8000_1000 + 64'(4 * i), $urandom);
      step($sformatf("stream%0d", i));
    end
    for (int i = 0; i < 80; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 9) == 0,
            {32'h8000_2000, 32'(4 * i)}, $urandom);
      step($sformatf("rand%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0);
      step($sformatf("drain%0d", i));
    end
    drive(1, 0, 0, 64'h8000_3000, 32'h0F13);
    step("arst_fill");
    drive(0, 0, 0, 0, 0);
    #3;
    rst = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", 64'(count), 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_pc", out_pc, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1;
    drive(1, 0, 0, 64'h8000_3004, 32'h1013);
    step("post_rst_push");
    drive(0, 1, 0, 0, 0);
    step("post_rst_pop");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_22050133_ifq.md
# ysyx_22050133_ifq

Instruction fetch queue between the fetch stage and the decode stage of the 64-bit RV core. It accepts {pc, inst} pairs from fetch with a valid/ready handshake, buffers up to DEPTH of them in order, and presents the oldest to decode. A flush from the redirect path (branch/jump resolved in execute) discards all buffered wrong-path instructions.

## Interface
- DEPTH, 2: number of entries; power of two, ≥ 2.
- clk  input  1  core clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- flush  input  1  discard queue contents and the current input beat.
- in_valid  input  1  fetch offers a beat.
- in_ready  output  1  queue accepts the beat.
- in_pc  input  64  PC of offered instruction.
- in_inst  input  32  instruction word.
- out_valid  output  1  oldest entry available to decode.
- out_ready  input  1  decode consumes the entry.
- out_pc  output  64  PC of oldest entry.
- out_inst  output  32  instruction of oldest entry.
- count  output  log2(DEPTH)+1  current occupancy.

## Operation
- Entry = {pc[63:0], inst[31:0]}, 96 bits.
- Push when in_valid && in_ready && !flush; pop when out_valid && out_ready.
- in_ready = (count != DEPTH); it does not depend on out_ready. Full queue refuses a push even with a simultaneous pop.
- out_valid = (count != 0) && !flush.
- out_pc/out_inst = head entry when out_valid = 1, otherwise 0.
- Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count updates +1 on push only, −1 on pop only, and is unchanged on push+pop.
- Flush on a clock edge sets count, rd_ptr and wr_ptr to 0 and drops the beat offered in that cycle. In that cycle in_ready stays !full, so fetch sees the beat as taken and redirects. No pop occurs during flush.
- Order is strict FIFO with no reordering and no duplication.

## Timing
- Reset (rst = 0, asynchronous): count = 0, pointers = 0, out_valid = 0, in_ready = 1, out_pc = 0, out_inst = 0. Storage contents are not reset.
- Without bypass: push at edge N makes the entry visible on out_* after edge N, so latency is 1 cycle.
- Throughput is one push and one pop per cycle in steady state when not full.
- Full (count = DEPTH): in_ready = 0. A pop at edge N raises in_ready after edge N.
- Empty: out_valid = 0. Asserting out_ready has no effect.
- Flush and push in the same cycle: flush wins.
- Flush and pop in the same cycle: out_valid is masked, so no pop.
- rst asserted mid-operation clears state immediately. After release, the first push is allowed on the next edge.

## Configuration
- YSYX_22050133_IFQ_BYPASS_EN
  - Defined: when count = 0 and in_valid = 1 and flush = 0, out_valid = 1 and out_pc/out_inst = in_pc/in_inst combinationally. If out_ready = 1 as well, the beat is consumed without being written (count stays 0). If out_ready = 0, it is written normally. Zero-cycle latency when empty.
  - Undefined: no combinational path from in_* to out_*; latency is 1 cycle as above.

## Structure
- Shared package ysyx_22050133_pkg holds:
  - typedef ifq_entry_t (pc, inst fields);
  - constant PC_W = 64;
  - constant INST_W = 32.
- One sub-module ysyx_22050133_ifq_mem: DEPTH × 96-bit register array with one synchronous write port and one asynchronous read port, no reset.
- Pointer, count and handshake logic live in the top module.

## Test plan
- Reset and fill: release rst; push pc 0x8000_0000 / inst 0x0000_0413, then 0x8000_0004 / 0x0000_0513, with out_ready = 0. Expect count = 2, in_ready = 0, out_pc = 0x8000_0000.
- Drain order: from the full state, set out_ready = 1 for 2 cycles. Expect out_pc 0x8000_0000 then 0x8000_0004, then out_valid = 0 and count = 0.
- Streaming: in_valid = out_ready = 1 for 20 cycles with pc incrementing by 4. Expect one output per cycle in order, count constant, and pointer wrap exercised.
- Flush: with 2 entries plus in_valid = 1 at pc 0x8000_0010, pulse flush one cycle. Expect out_valid = 0 during the pulse, count = 0 after it, and pc 0x8000_0010 never emitted.
- Async reset mid-stream: drop rst between edges while count = 1. Expect out_valid = 0 and count = 0 immediately, before the next edge.
- Bypass (macro defined): empty queue, in_valid = out_ready = 1, pc 0x8000_0020. Expect out_valid = 1 and out_pc = 0x8000_0020 in the same cycle, with count staying 0.
